// File: rtl/dcache_write_buffer_pkg.sv
// Shared sizing defaults for the data-cache write-back buffer and its line FIFO.
package dcache_write_buffer_pkg;
  localparam int WB_DEPTH_DEF    = 4;
  localparam int WB_LINE_W_DEF   = 256;
  localparam int WB_ADDR_W_DEF   = 32;
  localparam int WB_OFFSET_W_DEF = 5;
endpackage

// File: rtl/dcache_write_buffer_wb_line_fifo.sv
// Line-entry FIFO for evicted dirty lines: storage, pointers, occupancy and
// per-entry valid bits, with line addresses exported for miss-ordering checks.
module wb_line_fifo
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH_DEF,
  parameter int LINE_W   = WB_LINE_W_DEF,
  parameter int ADDR_W   = WB_ADDR_W_DEF,
  parameter int OFFSET_W = WB_OFFSET_W_DEF,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1,
  localparam int LA_W    = ADDR_W - OFFSET_W
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        push_i,
  input  logic [ADDR_W-1:0]           push_addr_i,
  input  logic [LINE_W-1:0]           push_data_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [CW-1:0]               count_o,
  output logic [ADDR_W-1:0]           head_addr_o,
  output logic [LINE_W-1:0]           head_data_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [DEPTH-1:0][LA_W-1:0]  line_o
);
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_q;
  logic [DEPTH-1:0][LINE_W-1:0]  data_q;
  logic                          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop never frees space for a push in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      addr_q[wr_ptr_q] <= push_addr_i;
      data_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o     = count_q;
  assign head_addr_o = addr_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign valid_o     = valid_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_line
    assign line_o[i] = addr_q[i][ADDR_W-1:OFFSET_W];
  end
endmodule

// File: rtl/dcache_write_buffer.sv
// Dirty-line write-back buffer between the data cache and cache_interface;
// stalls miss reads that hit a pending write-back line.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int DEPTH    = WB_DEPTH_DEF,
  parameter int LINE_W   = WB_LINE_W_DEF,
  parameter int ADDR_W   = WB_ADDR_W_DEF,
  parameter int OFFSET_W = WB_OFFSET_W_DEF,
  localparam int CW      = $clog2(DEPTH) + 1,
  localparam int LA_W    = ADDR_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              up_wen,
  input  logic [ADDR_W-1:0] up_waddr,
  input  logic [LINE_W-1:0] up_wdata,
  output logic              up_wfin,
  input  logic              up_ren,
  input  logic [ADDR_W-1:0] up_raddr,
  output logic              up_raccept,
  output logic              dn_wen,
  output logic [ADDR_W-1:0] dn_waddr,
  output logic [LINE_W-1:0] dn_wdata,
  input  logic              dn_wfin,
  output logic              dn_ren,
  output logic [ADDR_W-1:0] dn_raddr,
  input  logic              dn_raccept,
  output logic              empty,
  output logic [CW-1:0]     count
);
  logic                       full;
  logic [ADDR_W-1:0]          head_addr;
  logic [LINE_W-1:0]          head_data;
  logic [DEPTH-1:0]           ent_vld;
  logic [DEPTH-1:0][LA_W-1:0] ent_line;
  logic [DEPTH-1:0]           hit;
  logic [LA_W-1:0]            rline;
  logic                       conflict;

  wb_line_fifo #(
    .DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (up_wfin),
    .push_addr_i(up_waddr),
    .push_data_i(up_wdata),
    .pop_i      (dn_wfin & dn_wen),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count),
    .head_addr_o(head_addr),
    .head_data_o(head_data),
    .valid_o    (ent_vld),
    .line_o     (ent_line)
  );

  assign up_wfin  = up_wen & ~full;
  assign dn_wen   = ~empty;
  assign dn_waddr = empty ? '0 : head_addr;
  assign dn_wdata = empty ? '0 : head_data;

  assign rline = up_raddr[ADDR_W-1:OFFSET_W];
  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign hit[i] = ent_vld[i] & (ent_line[i] == rline);
  end

  // A line being pushed this very cycle also blocks the miss.
  assign conflict   = (|hit) | (up_wfin & (up_waddr[ADDR_W-1:OFFSET_W] == rline));
  assign dn_ren     = up_ren & ~conflict;
  assign dn_raddr   = up_raddr;
  assign up_raccept = dn_raccept & dn_ren;
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a scoreboard on the drain port.
module tb_dcache_write_buffer;
  localparam int DEPTH = 4;
  localparam int LW    = 256;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          up_wen, up_ren, dn_wfin, dn_raccept;
  logic [AW-1:0] up_waddr, up_raddr, dn_waddr, dn_raddr;
  logic [LW-1:0] up_wdata, dn_wdata;
  logic          up_wfin, up_raccept, dn_wen, dn_ren, empty;
  logic [2:0]    count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } ent_t;
  ent_t exp_q[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_write_buffer dut (
    .clk(clk), .resetn(resetn),
    .up_wen(up_wen), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wfin(up_wfin),
    .up_ren(up_ren), .up_raddr(up_raddr), .up_raccept(up_raccept),
    .dn_wen(dn_wen), .dn_waddr(dn_waddr), .dn_wdata(dn_wdata), .dn_wfin(dn_wfin),
    .dn_ren(dn_ren), .dn_raddr(dn_raddr), .dn_raccept(dn_raccept),
    .empty(empty), .count(count)
  );

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Scoreboard: expected lines enter on accepted pushes, leave on drain handshakes.
  always @(negedge clk) begin
    if (resetn) begin
      if (dn_wen && dn_wfin) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL drain_unexpected: got addr %0h want no drain", dn_waddr);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if (dn_waddr !== e.addr || dn_wdata !== e.data) begin
            bad++;
            $display("FAIL drain_order: got addr %0h want %0h (data match %0b)",
                     dn_waddr, e.addr, dn_wdata === e.data);
          end
        end
      end
      if (up_wen && up_wfin) exp_q.push_back('{addr: up_waddr, data: up_wdata});
    end
  end

  task automatic single_push(input logic [AW-1:0] a, input string tag);
    up_wen = 1'b1; up_waddr = a; up_wdata = pat(a);
    @(negedge clk);
    chk({tag, "_wfin"}, LW'(up_wfin), LW'(1));
    chk({tag, "_wen_not_yet"}, LW'(dn_wen), LW'(0));
    step(); up_wen = 1'b0;
    @(negedge clk);
    chk({tag, "_dn_wen"}, LW'(dn_wen), LW'(1));
    chk({tag, "_dn_waddr"}, LW'(dn_waddr), LW'(a));
    chk({tag, "_dn_wdata"}, dn_wdata, pat(a));
    chk({tag, "_count1"}, LW'(count), LW'(1));
    step(); dn_wfin = 1'b1;
    step(); dn_wfin = 1'b0;
    @(negedge clk);
    chk({tag, "_empty"}, LW'(empty), LW'(1));
    chk({tag, "_count0"}, LW'(count), LW'(0));
    chk({tag, "_sb_drained"}, LW'(exp_q.size()), LW'(0));
    step();
  endtask

  initial begin
    resetn = 1'b0; up_wen = 0; up_ren = 0; dn_wfin = 0; dn_raccept = 0;
    up_waddr = '0; up_raddr = '0; up_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dn_wen", LW'(dn_wen), LW'(0));
    chk("rst_dn_waddr", LW'(dn_waddr), LW'(0));
    chk("rst_dn_wdata", dn_wdata, '0);
    chk("rst_empty", LW'(empty), LW'(1));
    chk("rst_count", LW'(count), LW'(0));
    chk("rst_up_wfin", LW'(up_wfin), LW'(0));
    chk("rst_dn_ren", LW'(dn_ren), LW'(0));
    resetn = 1'b1;
    step();

    // 1: single write-back
    single_push(32'h0000_1020, "s1");

    // 2: fill to full, blocked push, pop then accept
    for (int i = 0; i < 4; i++) begin
      up_wen = 1'b1; up_waddr = 32'h100 + 32'(i) * 32'h20; up_wdata = pat(up_waddr);
      step();
    end
    up_waddr = 32'h180; up_wdata = pat(32'h180);
    @(negedge clk);
    chk("s2_count_full", LW'(count), LW'(4));
    chk("s2_wfin_full", LW'(up_wfin), LW'(0));
    chk("s2_head", LW'(dn_waddr), LW'(32'h100));
    step(); dn_wfin = 1'b1;
    @(negedge clk);
    chk("s2_wfin_full_pop", LW'(up_wfin), LW'(0));
    step(); dn_wfin = 1'b0;
    @(negedge clk);
    chk("s2_wfin_after_pop", LW'(up_wfin), LW'(1));
    chk("s2_count3", LW'(count), LW'(3));
    step(); up_wen = 1'b0;
    @(negedge clk);
    chk("s2_count_refull", LW'(count), LW'(4));
    step(); dn_wfin = 1'b1;
    repeat (4) step();
    dn_wfin = 1'b0;
    @(negedge clk);
    chk("s2_empty", LW'(empty), LW'(1));
    chk("s2_sb_drained", LW'(exp_q.size()), LW'(0));
    step();

    // 3: pointer wrap with alternating drain
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          bit ok;
          ok = 1'b0;
          up_wen = 1'b1; up_waddr = 32'h8000 + 32'(i) * 32'h20; up_wdata = pat(up_waddr);
          for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (up_wfin) begin ok = 1'b1; break; end
            @(posedge clk); #1;
          end
          if (!ok) begin
            total++; bad++;
            $display("FAIL s3_push_timeout: got no up_wfin want up_wfin for push %0d", i);
          end
          step();
        end
        up_wen = 1'b0;
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          chk("s3_count_le_depth", LW'(count <= 3'(DEPTH)), LW'(1));
          @(posedge clk); #1;
          dn_wfin = c[0];
        end
        dn_wfin = 1'b0;
      end
    join
    @(negedge clk);
    chk("s3_empty", LW'(empty), LW'(1));
    chk("s3_sb_drained", LW'(exp_q.size()), LW'(0));
    step();

    // 4: miss conflict with a pending line, and a non-matching pass-through
    up_wen = 1'b1; up_waddr = 32'h0000_2040; up_wdata = pat(up_waddr);
    step(); up_wen = 1'b0;
    up_ren = 1'b1; up_raddr = 32'h0000_205C; dn_raccept = 1'b1;
    @(negedge clk);
    chk("s4_conflict_ren", LW'(dn_ren), LW'(0));
    chk("s4_conflict_acc", LW'(up_raccept), LW'(0));
    step(); up_raddr = 32'h0000_3000;
    @(negedge clk);
    chk("s4_pass_ren", LW'(dn_ren), LW'(1));
    chk("s4_pass_raddr", LW'(dn_raddr), LW'(32'h0000_3000));
    chk("s4_pass_acc", LW'(up_raccept), LW'(1));
    step(); up_raddr = 32'h0000_205C; dn_wfin = 1'b1;
    @(negedge clk);
    chk("s4_ren_during_pop", LW'(dn_ren), LW'(0));
    step(); dn_wfin = 1'b0;
    @(negedge clk);
    chk("s4_ren_after_pop", LW'(dn_ren), LW'(1));
    chk("s4_acc_after_pop", LW'(up_raccept), LW'(1));
    step(); dn_raccept = 1'b0;
    @(negedge clk);
    chk("s4_acc_no_dn", LW'(up_raccept), LW'(0));
    step(); up_ren = 1'b0;

    // 5: same-cycle push/miss conflict
    up_wen = 1'b1; up_waddr = 32'h400; up_wdata = pat(up_waddr);
    up_ren = 1'b1; up_raddr = 32'h41C; dn_raccept = 1'b1;
    @(negedge clk);
    chk("s5_wfin", LW'(up_wfin), LW'(1));
    chk("s5_ren_same_cycle", LW'(dn_ren), LW'(0));
    step(); up_wen = 1'b0;
    @(negedge clk);
    chk("s5_ren_pending", LW'(dn_ren), LW'(0));
    step(); dn_wfin = 1'b1;
    @(negedge clk);
    chk("s5_ren_popping", LW'(dn_ren), LW'(0));
    step(); dn_wfin = 1'b0;
    @(negedge clk);
    chk("s5_ren_released", LW'(dn_ren), LW'(1));
    step(); up_ren = 1'b0; dn_raccept = 1'b0;

    // 6: asynchronous reset with entries pending
    for (int i = 0; i < 3; i++) begin
      up_wen = 1'b1; up_waddr = 32'h500 + 32'(i) * 32'h20; up_wdata = pat(up_waddr);
      step();
    end
    up_wen = 1'b0;
    @(negedge clk);
    chk("s6_count3", LW'(count), LW'(3));
    chk("s6_wen_hi", LW'(dn_wen), LW'(1));
    #2 resetn = 1'b0;
    #1;
    chk("s6_async_wen", LW'(dn_wen), LW'(0));
    chk("s6_async_count", LW'(count), LW'(0));
    chk("s6_async_waddr", LW'(dn_waddr), LW'(0));
    exp_q.delete();
    step(); resetn = 1'b1;
    step();
    single_push(32'h0000_1020, "s6_post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
